// File: rtl/delay_mem_sweep_ctrl_if.sv
// Memory-side bus of the sweep controller: write qualifier, op select,
// word address and the combinational read data that comes back.
interface delay_mem_sweep_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_enable;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;

  // Controller side drives the request, memory side returns read data.
  modport master (
    output mem_req,
    output mem_enable,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_enable,
    input  mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/delay_mem_sweep_ctrl.sv
// Sweep controller for the read-modify-write counter memory.
// A start command sweeps a wrapping window of addresses (one per cycle),
// summing and max-tracking the pre-modification values. Increment sweeps
// are followed by a read-only verify pass that counts words that did not
// come back as old+1.
module delay_mem_sweep_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_start,
  input  logic                          io_mode,
  input  logic [IDX_W-1:0]              io_base,
  input  logic [IDX_W:0]                io_len,
  delay_mem_sweep_ctrl_if.master        mem,
  output logic                          io_busy,
  output logic                          io_done,
  output logic [WIDTH-1:0]              io_sum,
  output logic [WIDTH-1:0]              io_max,
  output logic [IDX_W:0]                io_errs
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W:0] LEN_FULL = (IDX_W+1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDX_W:0]   errs_q, errs_d;
  logic [WIDTH-1:0] shadow_q [DEPTH];

  logic [IDX_W-1:0] idx_s;
  logic             last_s;

  // Window index wraps naturally in IDX_W bits (DEPTH is a power of two).
  assign idx_s  = base_q + i_q;
  assign last_s = ({1'b0, i_q} == (len_q - (IDX_W+1)'(1)));

  assign io_busy = (state_q == S_RUN) || (state_q == S_VERIFY);
  assign io_done = (state_q == S_DONE);
  assign io_sum  = sum_q;
  assign io_max  = max_q;
  assign io_errs = errs_q;

  // Memory bus decode: writes are only ever qualified while sweeping in RUN.
  always_comb begin
    mem.mem_req    = 1'b0;
    mem.mem_enable = 1'b0;
    mem.mem_addr   = {WIDTH{1'b0}};
    case (state_q)
      S_RUN: begin
        mem.mem_req    = 1'b1;
        mem.mem_enable = ~mode_q;
        mem.mem_addr   = {{(WIDTH-IDX_W){1'b0}}, idx_s};
      end
      S_VERIFY: begin
        mem.mem_addr   = {{(WIDTH-IDX_W){1'b0}}, idx_s};
      end
      default: begin
        mem.mem_req    = 1'b0;
      end
    endcase
  end

  // Sequencer next-state: command latch, sweep stepping and accumulators.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    len_d   = len_q;
    i_d     = i_q;
    sum_d   = sum_q;
    max_d   = max_q;
    errs_d  = errs_q;
    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          mode_d  = io_mode;
          base_d  = io_base;
          len_d   = (io_len == (IDX_W+1)'(0)) ? LEN_FULL : io_len;
          i_d     = {IDX_W{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          max_d   = {WIDTH{1'b0}};
          errs_d  = {(IDX_W+1){1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d = sum_q + mem.mem_rdata;
        if (mem.mem_rdata > max_q) begin
          max_d = mem.mem_rdata;
        end else begin
          max_d = max_q;
        end
        if (last_s) begin
          i_d     = {IDX_W{1'b0}};
          state_d = mode_q ? S_DONE : S_VERIFY;
        end else begin
          i_d     = i_q + IDX_W'(1);
        end
      end
      S_VERIFY: begin
        if ((mem.mem_rdata != shadow_q[i_q]) && (errs_q != LEN_FULL)) begin
          errs_d = errs_q + (IDX_W+1)'(1);
        end else begin
          errs_d = errs_q;
        end
        if (last_s) begin
          i_d     = {IDX_W{1'b0}};
          state_d = S_DONE;
        end else begin
          i_d     = i_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      base_q  <= {IDX_W{1'b0}};
      len_q   <= {(IDX_W+1){1'b0}};
      i_q     <= {IDX_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      max_q   <= {WIDTH{1'b0}};
      errs_q  <= {(IDX_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      len_q   <= len_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      errs_q  <= errs_d;
    end
  end

  // Expected post-increment values, indexed by sweep position, for verify.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        shadow_q[k] <= {WIDTH{1'b0}};
      end
    end else if ((state_q == S_RUN) && !mode_q) begin
      shadow_q[i_q] <= mem.mem_rdata + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_delay_mem_sweep_ctrl.sv
// Self-checking bench for delay_mem_sweep_ctrl with an 8-word counter
// memory model and a sweep-level reference model.
module tb_delay_mem_sweep_ctrl;

  logic        clk;
  logic        reset;
  logic        io_start;
  logic        io_mode;
  logic [2:0]  io_base;
  logic [3:0]  io_len;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_sum;
  logic [31:0] io_max;
  logic [3:0]  io_errs;

  logic [31:0] mem [8];

  int checks   = 0;
  int failures = 0;

  delay_mem_sweep_ctrl_if #(.WIDTH(32)) bus ();

  assign bus.mem_rdata = mem[bus.mem_addr[2:0]];

  delay_mem_sweep_ctrl #(.DEPTH(8), .WIDTH(32), .IDX_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_start (io_start),
    .io_mode  (io_mode),
    .io_base  (io_base),
    .io_len   (io_len),
    .mem      (bus.master),
    .io_busy  (io_busy),
    .io_done  (io_done),
    .io_sum   (io_sum),
    .io_max   (io_max),
    .io_errs  (io_errs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: the memory model commits the write qualified during the
  // cycle just ended, shortly after the edge; outputs are then stable.
  task automatic tick();
    logic       req_c;
    logic       en_c;
    logic [2:0] a_c;
    req_c = bus.mem_req;
    en_c  = bus.mem_enable;
    a_c   = bus.mem_addr[2:0];
    @(posedge clk);
    #1;
    if (req_c === 1'b1) begin
      if (en_c === 1'b1) mem[a_c] = mem[a_c] + 32'd1;
      else               mem[a_c] = mem[3'(a_c + 3'd4)];
    end
  endtask

  task automatic mem_linear();
    for (int k = 0; k < 8; k++) mem[k] = 32'(10 * k);
  endtask

  task automatic test_reset();
    io_start = 1'b0; io_mode = 1'b0; io_base = 3'd0; io_len = 4'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({io_busy, io_done, bus.mem_req, bus.mem_enable} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {io_busy, io_done, bus.mem_req, bus.mem_enable});
    end
    checks++;
    if (io_sum !== 32'd0 || io_max !== 32'd0 || io_errs !== 4'd0 || bus.mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got sum=%0h max=%0h errs=%0h addr=%0h exp=0", io_sum, io_max, io_errs, bus.mem_addr);
    end
  endtask

  // Full sweep against a reference computed from the current memory image.
  task automatic run_sweep(input logic mode, input int base, input int len_raw,
                           input bit fault, input bit extra, input string name);
    int          len;
    int          done_cyc;
    int          exp_errs;
    int          dones;
    int          addrs [8];
    logic [31:0] m [8];
    logic [31:0] shadow [8];
    logic [31:0] exp_sum;
    logic [31:0] exp_max;
    logic [31:0] v;
    bit          exp_busy;
    len = (len_raw == 0) ? 8 : len_raw;
    for (int k = 0; k < 8; k++) m[k] = mem[k];
    exp_sum = 32'd0; exp_max = 32'd0; exp_errs = 0;
    for (int i = 0; i < len; i++) begin
      addrs[i] = (base + i) % 8;
      v = m[addrs[i]];
      exp_sum = exp_sum + v;
      if (v > exp_max) exp_max = v;
      if (mode == 1'b0) begin
        shadow[i] = v + 32'd1;
        m[addrs[i]] = v + 32'd1;
      end else begin
        m[addrs[i]] = m[(addrs[i] + 4) % 8];
      end
    end
    if (mode == 1'b0) begin
      if (fault) m[3] = 32'd0;
      for (int i = 0; i < len; i++) if (m[addrs[i]] != shadow[i]) exp_errs++;
    end
    done_cyc = (mode == 1'b0) ? 1 + 2 * len : 1 + len;

    io_start = 1'b1; io_mode = mode; io_base = 3'(base); io_len = 4'(len_raw);
    tick();
    io_start = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
      if (fault && mode == 1'b0 && cyc == len + 1) mem[3] = 32'd0;
      exp_busy = (cyc < done_cyc);
      checks++;
      if (io_busy !== exp_busy || io_done !== (cyc == done_cyc) || bus.mem_req !== (cyc <= len)) begin
        failures++;
        $display("FAIL %s ctrl cyc=%0d got busy/done/req=%b%b%b exp=%b%b%b", name, cyc,
                 io_busy, io_done, bus.mem_req, exp_busy, (cyc == done_cyc), (cyc <= len));
      end
      if (io_done === 1'b1) dones++;
      if (cyc <= len) begin
        checks++;
        if (bus.mem_addr !== 32'(addrs[cyc-1]) || bus.mem_enable !== ~mode) begin
          failures++;
          $display("FAIL %s run_bus cyc=%0d got addr=%0d en=%b exp addr=%0d en=%b", name, cyc,
                   bus.mem_addr, bus.mem_enable, addrs[cyc-1], ~mode);
        end
      end else if (cyc < done_cyc) begin
        checks++;
        if (bus.mem_addr !== 32'(addrs[cyc-len-1]) || bus.mem_enable !== 1'b0) begin
          failures++;
          $display("FAIL %s verify_bus cyc=%0d got addr=%0d en=%b exp addr=%0d en=0", name, cyc,
                   bus.mem_addr, bus.mem_enable, addrs[cyc-len-1]);
        end
      end
      if (extra && cyc == 2) begin
        io_start = 1'b1; io_mode = ~mode; io_base = 3'(base + 1); io_len = 4'd3;
      end else begin
        io_start = 1'b0;
      end
      tick();
    end
    io_start = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s done_count got=%0d exp=1", name, dones);
    end
    checks++;
    if (io_sum !== exp_sum || io_max !== exp_max || io_errs !== 4'(exp_errs)) begin
      failures++;
      $display("FAIL %s results got sum=%0d max=%0d errs=%0d exp sum=%0d max=%0d errs=%0d", name,
               io_sum, io_max, io_errs, exp_sum, exp_max, exp_errs);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[k] !== m[k]) begin
        failures++;
        $display("FAIL %s mem[%0d] got=%0d exp=%0d", name, k, mem[k], m[k]);
      end
    end
  endtask

  task automatic test_directed();
    mem_linear(); run_sweep(1'b0, 0, 8, 1'b0, 1'b0, "inc_full");
    mem_linear(); run_sweep(1'b0, 6, 4, 1'b0, 1'b0, "inc_wrap");
    mem_linear(); run_sweep(1'b1, 0, 2, 1'b0, 1'b0, "copy_short");
    mem_linear(); run_sweep(1'b0, 0, 8, 1'b1, 1'b0, "verify_fault");
    mem_linear(); run_sweep(1'b0, 0, 0, 1'b0, 1'b1, "len_zero_restart");
  endtask

  task automatic test_abort();
    mem_linear();
    io_start = 1'b1; io_mode = 1'b0; io_base = 3'd2; io_len = 4'd8;
    tick();
    io_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({io_busy, io_done, bus.mem_req} !== 3'b000 || io_sum !== 32'd0 || io_max !== 32'd0 || io_errs !== 4'd0) begin
      failures++;
      $display("FAIL abort got busy/done/req=%b%b%b sum=%0d max=%0d errs=%0d exp all 0",
               io_busy, io_done, bus.mem_req, io_sum, io_max, io_errs);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (io_done !== 1'b0 || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d got done=%b req=%b exp=0 0", c, io_done, bus.mem_req);
      end
      tick();
    end
    run_sweep(1'b0, 5, 6, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 8; k++) mem[k] = $urandom();
      if (r == 0) mem[$urandom_range(0, 7)] = 32'hFFFF_FFFF;
      run_sweep(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                1'b0, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 8; k++) mem[k] = 32'd0;
    test_reset();
    test_directed();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
